// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit encoding, port indices, link credit depth and
// the allocator state encoding.
package noc_pkg;

  localparam int FLIT_W    = 16;
  localparam int NUM_PORTS = 5;

  localparam int PORT_N = 0;
  localparam int PORT_S = 1;
  localparam int PORT_E = 2;
  localparam int PORT_W = 3;
  localparam int PORT_L = 4;

  localparam int CREDITS = 5;

  // Flit type lives in the two MSBs of every flit.
  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] flit);
    return flit_type_e'(flit[FLIT_W-1 -: 2]);
  endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin picker: grants the first requester found when
// searching upward from ptr, wrapping modulo N. Output is one-hot or zero.
module noc_rr_arbiter #(
  parameter int N = 5
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  logic found;
  int   idx;

  // Scan N positions starting at ptr; the first set request wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_output_arbiter.sv
// Wormhole output allocator for one router direction: grants whole packets in
// round-robin order, gates every flit on downstream credits and registers the
// granted flit onto the link.
module noc_output_arbiter #(
  parameter int NUM_IN  = noc_pkg::NUM_PORTS,
  parameter int FLIT_W  = noc_pkg::FLIT_W,
  parameter int CREDITS = noc_pkg::CREDITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN-1:0]            req_i,
  input  logic [NUM_IN*FLIT_W-1:0]     flit_i,
  output logic [NUM_IN-1:0]            grant_o,
  input  logic                         inc_credit_i,
  output logic [FLIT_W-1:0]            data_o,
  output logic                         send_data,
  output logic [$clog2(CREDITS+1)-1:0] credit_cnt_o,
  output logic                         err_o
);

  import noc_pkg::*;

  localparam int PW = $clog2(NUM_IN);
  localparam int CW = $clog2(CREDITS + 1);

  arb_state_e        state_q, state_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic [FLIT_W-1:0] data_q, data_d;
  logic              send_q, send_d;
  logic              err_q, err_d;

  flit_type_e        ftype [NUM_IN];
  logic [NUM_IN-1:0] head_req;
  logic [NUM_IN-1:0] rr_gnt;
  logic [NUM_IN-1:0] grant;
  logic [PW-1:0]     sel_idx;
  logic              has_credit;
  logic              granted;
  logic              proto_err;
  logic              credit_err;

  // Decode each input's flit type; only HEAD/SINGLE may open a packet.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_type
    assign ftype[i]    = flit_type_e'(flit_i[i*FLIT_W + FLIT_W - 2 +: 2]);
    assign head_req[i] = req_i[i] && (ftype[i] == FLIT_HEAD || ftype[i] == FLIT_SINGLE);
  end

  noc_rr_arbiter #(.N(NUM_IN)) u_rr (
    .req (head_req),
    .ptr (rr_ptr_q),
    .gnt (rr_gnt)
  );

  assign has_credit = (credit_q != '0);

  // Packet-lock FSM: pick a new packet owner when idle, follow the owner when locked.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    grant     = '0;
    sel_idx   = owner_q;
    proto_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        for (int i = 0; i < NUM_IN; i++) begin
          if (rr_gnt[i]) sel_idx = PW'(i);
          if (req_i[i] && !head_req[i]) proto_err = 1'b1;
        end
        if (has_credit && (rr_gnt != '0)) begin
          grant    = rr_gnt;
          rr_ptr_d = (sel_idx == PW'(NUM_IN - 1)) ? '0 : sel_idx + 1'b1;
          if (ftype[sel_idx] == FLIT_HEAD) begin
            state_d = ST_LOCKED;
            owner_d = sel_idx;
          end
        end
      end
      ST_LOCKED: begin
        if (req_i[owner_q]) begin
          if (ftype[owner_q] == FLIT_HEAD || ftype[owner_q] == FLIT_SINGLE) begin
            proto_err = 1'b1;
          end else if (has_credit) begin
            grant[owner_q] = 1'b1;
            if (ftype[owner_q] == FLIT_TAIL) state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) grant = '0;
  end

  assign grant_o = grant;
  assign granted = |grant;

  // Credit bookkeeping, link register next values and sticky error accumulation.
  always_comb begin
    credit_d   = credit_q;
    credit_err = 1'b0;
    send_d     = granted;
    data_d     = data_q;
    if (granted) data_d = flit_i[sel_idx*FLIT_W +: FLIT_W];
    case ({granted, inc_credit_i})
      2'b10: credit_d = credit_q - 1'b1;
      2'b01: begin
        if (credit_q == CW'(CREDITS)) credit_err = 1'b1;
        else                          credit_d   = credit_q + 1'b1;
      end
      default: credit_d = credit_q;
    endcase
    err_d = err_q | proto_err | credit_err;
  end

  // State registers with synchronous reset; a reset mid-packet drops the lock.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      credit_q <= CW'(CREDITS);
      data_q   <= '0;
      send_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      credit_q <= credit_d;
      data_q   <= data_d;
      send_q   <= send_d;
      err_q    <= err_d;
    end
  end

  assign data_o       = data_q;
  assign send_data    = send_q;
  assign credit_cnt_o = credit_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed bench for noc_output_arbiter. The driver checks grant_o, credits
// and err_o directly and queues every flit it expects on the link; a monitor
// on the falling edge pops that queue whenever send_data is high.
module tb_noc_output_arbiter;
  import noc_pkg::*;

  localparam int N = 5;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_i;
  logic [N*W-1:0] flit_i;
  logic [N-1:0]   grant_o;
  logic           inc_credit_i;
  logic [W-1:0]   data_o;
  logic           send_data;
  logic [2:0]     credit_cnt_o;
  logic           err_o;

  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] mon_exp;

  localparam logic [W-1:0] T2_IN0 [6] = '{16'h4001, 16'h0002, 16'h8003, 16'h0000, 16'h0000, 16'h0000};
  localparam logic [W-1:0] T2_IN3 [6] = '{16'h4031, 16'h4031, 16'h4031, 16'h4031, 16'h0032, 16'h8033};
  localparam logic [N-1:0] T2_GNT [6] = '{5'b00001, 5'b00001, 5'b00001, 5'b01000, 5'b01000, 5'b01000};

  localparam logic [W-1:0] T3_FLIT [7] = '{16'h4101, 16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'h0106, 16'h8107};
  localparam logic         T3_INC  [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
  localparam logic         T3_GNT  [10] = '{1, 1, 1, 1, 1, 0, 0, 1, 0, 1};
  localparam int           T3_CRED [10] = '{5, 4, 3, 2, 1, 0, 0, 1, 0, 1};

  always #5 clk = ~clk;

  noc_output_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .flit_i       (flit_i),
    .grant_o      (grant_o),
    .inc_credit_i (inc_credit_i),
    .data_o       (data_o),
    .send_data    (send_data),
    .credit_cnt_o (credit_cnt_o),
    .err_o        (err_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [W-1:0] f);
    req_i[i]        = 1'b1;
    flit_i[i*W +: W] = f;
  endtask

  task automatic idle_inputs();
    req_i        = '0;
    inc_credit_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  // Link monitor: every registered send must match the next queued flit.
  always @(negedge clk) begin
    if (send_data === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_send: data_o=%h with no flit expected at %0t", data_o, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("link_flit", 32'(data_o), 32'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] eg;
    int           fi;

    rst          = 1'b1;
    req_i        = '0;
    flit_i       = '0;
    inc_credit_i = 1'b0;

    // Reset state, with a request pending that must not be granted under reset.
    drive(PORT_E, 16'hC0A5);
    tick();
    tick();
    check("rst_grant", 32'(grant_o), 32'(0));
    check("rst_credit", 32'(credit_cnt_o), 32'(5));
    check("rst_send", 32'(send_data), 32'(0));
    check("rst_data", 32'(data_o), 32'(0));
    check("rst_err", 32'(err_o), 32'(0));

    // Single SINGLE flit on input 2.
    rst = 1'b0;
    #1;
    check("t1_grant", 32'(grant_o), 32'(5'b00100));
    exp_q.push_back(16'hC0A5);
    tick();
    idle_inputs();
    check("t1_credit", 32'(credit_cnt_o), 32'(4));

    // Two 3-flit packets from inputs 0 and 3 at once, credits replenished each cycle.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      req_i = '0;
      if (k < 3) drive(PORT_N, T2_IN0[k]);
      drive(PORT_W, T2_IN3[k]);
      inc_credit_i = 1'b1;
      #1;
      check("t2_grant", 32'(grant_o), 32'(T2_GNT[k]));
      exp_q.push_back((k < 3) ? T2_IN0[k] : T2_IN3[k]);
      tick();
    end
    idle_inputs();
    check("t2_credit", 32'(credit_cnt_o), 32'(5));
    check("t2_err", 32'(err_o), 32'(0));

    // 7-flit packet on input 1 with no credit return, then two late credits.
    fi = 0;
    for (int k = 0; k < 10; k++) begin
      req_i = '0;
      drive(PORT_S, T3_FLIT[fi]);
      inc_credit_i = T3_INC[k];
      #1;
      check("t3_credit", 32'(credit_cnt_o), 32'(T3_CRED[k]));
      check("t3_grant", 32'(grant_o), T3_GNT[k] ? 32'(5'b00010) : 32'(0));
      if (T3_GNT[k]) begin
        exp_q.push_back(T3_FLIT[fi]);
        fi++;
      end
      tick();
    end
    idle_inputs();
    check("t3_credit_end", 32'(credit_cnt_o), 32'(0));
    inc_credit_i = 1'b1;
    repeat (5) tick();
    inc_credit_i = 1'b0;
    check("t3_refill", 32'(credit_cnt_o), 32'(5));
    check("t3_err", 32'(err_o), 32'(0));

    // Grant plus credit at count 3, then credit overflow at count 5.
    drive(PORT_E, 16'hC201);
    #1;
    check("t4_grant_a", 32'(grant_o), 32'(5'b00100));
    exp_q.push_back(16'hC201);
    tick();
    drive(PORT_E, 16'hC202);
    #1;
    check("t4_grant_b", 32'(grant_o), 32'(5'b00100));
    exp_q.push_back(16'hC202);
    tick();
    check("t4_credit3", 32'(credit_cnt_o), 32'(3));
    drive(PORT_E, 16'hC203);
    inc_credit_i = 1'b1;
    #1;
    check("t4_grant_c", 32'(grant_o), 32'(5'b00100));
    exp_q.push_back(16'hC203);
    tick();
    idle_inputs();
    check("t4_credit_same", 32'(credit_cnt_o), 32'(3));
    inc_credit_i = 1'b1;
    tick();
    tick();
    check("t4_credit5", 32'(credit_cnt_o), 32'(5));
    check("t4_err_before", 32'(err_o), 32'(0));
    tick();
    inc_credit_i = 1'b0;
    check("t4_credit_sat", 32'(credit_cnt_o), 32'(5));
    check("t4_err_ovf", 32'(err_o), 32'(1));

    // Reset while input 1 holds a packet lock.
    do_reset();
    check("t5_rst_credit", 32'(credit_cnt_o), 32'(5));
    check("t5_rst_data", 32'(data_o), 32'(0));
    check("t5_rst_err", 32'(err_o), 32'(0));
    drive(PORT_S, 16'h4111);
    #1;
    check("t5_head", 32'(grant_o), 32'(5'b00010));
    exp_q.push_back(16'h4111);
    tick();
    drive(PORT_S, 16'h0112);
    #1;
    check("t5_body", 32'(grant_o), 32'(5'b00010));
    exp_q.push_back(16'h0112);
    tick();
    drive(PORT_S, 16'h0113);
    rst = 1'b1;
    #1;
    check("t5_grant_in_rst", 32'(grant_o), 32'(0));
    tick();
    rst = 1'b0;
    check("t5_credit", 32'(credit_cnt_o), 32'(5));
    check("t5_send", 32'(send_data), 32'(0));
    #1;
    check("t5_body_idle", 32'(grant_o), 32'(0));
    tick();
    idle_inputs();
    check("t5_err", 32'(err_o), 32'(1));

    // All inputs stream SINGLE flits: grants rotate 0,1,2,3,4,0.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) drive(i, 16'hC300 | 16'(i << 4));
      inc_credit_i = 1'b1;
      #1;
      eg = 5'(1 << (k % N));
      check("t6_rotate", 32'(grant_o), 32'(eg));
      exp_q.push_back(16'hC300 | 16'((k % N) << 4));
      tick();
    end
    idle_inputs();
    check("t6_credit", 32'(credit_cnt_o), 32'(5));
    check("t6_err", 32'(err_o), 32'(0));

    tick();
    tick();
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc_output_arbiter.md
# noc_output_arbiter

Wormhole switch allocator for one router output direction. It shares one output link among `NUM_IN` router input ports, granting whole packets (head through tail) in round-robin order. It gates every flit on downstream credits and drives the registered flit and `send_data` strobe onto the link. Each router has one instance per output direction, sitting between the input buffers and the link.

## Interface
- `NUM_IN`, 5: number of requesting input ports (N, S, E, W, Local).
- `FLIT_W`, 16: flit width.
- `CREDITS`, 5: downstream buffer depth, equal to the initial and maximum credit count.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_i` input `NUM_IN`: input i holds a valid flit on its slice of `flit_i`.
- `flit_i` input `NUM_IN*FLIT_W`: flattened flits; input i occupies bits `[i*FLIT_W +: FLIT_W]`.
- `grant_o` output `NUM_IN`: one-hot or zero, combinational; input i's flit is consumed this cycle.
- `inc_credit_i` input 1: downstream freed one buffer slot.
- `data_o` output `FLIT_W`: registered flit to the link.
- `send_data` output 1: registered strobe; `data_o` valid this cycle.
- `credit_cnt_o` output `$clog2(CREDITS+1)`: current credit count.
- `err_o` output 1: sticky protocol error flag; cleared only by `rst`.

## Operation
- **Flit type** is `flit[FLIT_W-1 -: 2]`:
  - `01` HEAD
  - `00` BODY
  - `10` TAIL
  - `11` SINGLE (head and tail in one flit)
- **States:** IDLE (no owner) and LOCKED (owner = input index).
- **IDLE:**
  - Candidates are inputs with `req_i` set and type HEAD or SINGLE.
  - The round-robin picker starts its search at `rr_ptr`.
  - A grant is issued only if `credit_cnt > 0`.
  - On a HEAD grant: go to LOCKED with owner = i, and set `rr_ptr` to (i+1) mod `NUM_IN`.
  - On a SINGLE grant: stay IDLE, and set `rr_ptr` to (i+1) mod `NUM_IN`.
  - A request carrying BODY or TAIL while IDLE is never granted and sets `err_o`.
- **LOCKED:**
  - Only the owner is eligible. It is granted when `req_i[owner]` is set and `credit_cnt > 0`.
  - A TAIL grant returns to IDLE.
  - A HEAD or SINGLE from the owner while LOCKED is not granted and sets `err_o`.
  - Other inputs' requests are ignored, with no error.
  - `rr_ptr` is unchanged while LOCKED.
- **Credits:**
  - Counter resets to `CREDITS`.
  - A grant without `inc_credit_i` decrements it.
  - `inc_credit_i` without a grant increments it.
  - A grant and `inc_credit_i` together leave it unchanged.
  - `inc_credit_i` at `CREDITS` with no grant saturates the counter and sets `err_o`.
  - The counter never underflows, because grants require a count greater than 0.
- **Output register:** on a grant, `data_o` takes the granted flit and `send_data` is 1. Otherwise `send_data` is 0 and `data_o` holds its last value.

## Timing
- Reset values:
  - state IDLE, `rr_ptr` 0
  - `credit_cnt_o` = `CREDITS`
  - `data_o` 0, `send_data` 0, `err_o` 0
  - `grant_o` 0 while `rst` is high
- Reset mid-packet drops the lock immediately. Upstream restarts with a HEAD.
- `grant_o` is combinational from `req_i`, `flit_i`, state, `rr_ptr` and the registered credit count. It does not depend on `inc_credit_i` in the same cycle: a credit arriving at count 0 enables a grant one cycle later.
- Latency: a grant in cycle t puts `send_data`/`data_o` on the link in cycle t+1.
- `credit_cnt_o` reflects that grant from t+1.
- Throughput: one flit per cycle while credits last. Back-to-back packets from different inputs incur no bubble; the IDLE arbitration happens in the same cycle the tail is granted, for the next cycle.
- `err_o` is set in the cycle after the offending event.

## Structure
- `noc_pkg` holds:
  - `FLIT_W`, `NUM_PORTS`
  - port index constants `PORT_N`, `PORT_S`, `PORT_E`, `PORT_W`, `PORT_L`
  - `CREDITS`
  - enum `flit_type_e` (HEAD, BODY, TAIL, SINGLE)
  - helper function `flit_type(flit)`
- Sub-module `noc_rr_arbiter` (params `N`; inputs `req`, `ptr`; output one-hot `gnt`) is purely combinational. It is reused by the input-side VC allocator later.
- The FSM, credit counter, output register and error logic stay in `noc_output_arbiter`.

## Test plan
- Reset, then single SINGLE flit `16'hC0A5` on input 2: `grant_o` = `5'b00100` same cycle; next cycle `send_data` = 1 and `data_o` = `C0A5`; credits 5→4.
- Inputs 0 and 3 both send 3-flit packets (HEAD, BODY, TAIL) at once: input 0's 3 flits go out contiguously, then input 3's 3 flits with no bubble; input 3 is never granted mid-packet of input 0.
- No `inc_credit_i`, one input streaming a 7-flit packet: exactly 5 grants, then stall with `credit_cnt_o` = 0. Pulse `inc_credit_i` twice: 2 more grants, each one cycle after its credit.
- Grant and `inc_credit_i` in the same cycle at count 3: stays 3. `inc_credit_i` at count 5 with no grant: stays 5 and `err_o` = 1.
- Assert `rst` while LOCKED on input 1 mid-packet: next cycle state IDLE, credits 5, `send_data` 0. A BODY request from input 1 is then not granted and sets `err_o`.
- All 5 inputs send SINGLE flits continuously: grants rotate 0,1,2,3,4,0.
